// File: rtl/nibble_bus_arbiter.sv
// Round-robin owner arbiter for the 4-bit nibble bus with a one-cycle turnaround.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles when contended.
module nibble_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  bus_en,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("nibble_bus_arbiter: NREQ must be 2..8");
    end
    if (IDX_W < $clog2(NREQ)) begin : g_bad_idx
        $error("nibble_bus_arbiter: IDX_W too narrow for NREQ");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_hold
        $error("nibble_bus_arbiter: MAX_HOLD does not fit HOLD_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;
    logic             r_timeout;

    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic             w_own_req;
    logic             w_force;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Winner is the asserted request with the smallest cyclic distance from ptr.
    always_comb begin
        int d;
        int best;
        w_win = '0;
        w_any = 1'b0;
        best  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(r_ptr) + NREQ) % NREQ;
            if (req[i] && d < best) begin
                best  = d;
                w_win = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_own_req = |(req & r_gnt);
    assign w_ptr_nxt = IDX_W'((int'(r_idx) + 1) % NREQ);

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;

    // Counts grant cycles already completed; cleared whenever not granting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '0;
        end else if (r_state == S_GRANT) begin
            if (int'(r_hold) < MAX_HOLD) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end else begin
            r_hold <= '0;
        end
    end

    assign w_force = (int'(r_hold) + 1 >= MAX_HOLD) && |(req & ~r_gnt);
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE, S_TURN: begin
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_idx   <= w_win;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (!w_own_req || w_force) begin
                        r_state   <= S_TURN;
                        r_gnt     <= '0;
                        r_ptr     <= w_ptr_nxt;
                        r_timeout <= w_own_req;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign bus_en  = r_gnt;
    assign gnt_idx = r_idx;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Scoreboard bench for nibble_bus_arbiter: driver queues per-edge expectations,
// a negedge monitor pops and compares them; bus_en invariants checked every cycle.
module tb_nibble_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] bus_en;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [1:0] i;
        logic       b;
        logic       t;
    } exp_t;

    exp_t q[$];

    nibble_bus_arbiter #(
        .NREQ(4), .IDX_W(2), .MAX_HOLD(8), .HOLD_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .bus_en(bus_en),
        .gnt_idx(gnt_idx),
        .busy(busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Queue the outputs expected after the next rising edge, then advance.
    task automatic step(input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] i, input logic b, input logic t);
        exp_t e;
        req   = r;
        e.cyc = cyc + 1;
        e.g   = g;
        e.i   = i;
        e.b   = b;
        e.t   = t;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk("stale_entry", e.cyc, cyc);
            end else begin
                chk("gnt", int'(gnt), int'(e.g));
                chk("bus_en", int'(bus_en), int'(e.g));
                chk("gnt_idx", int'(gnt_idx), int'(e.i));
                chk("busy", int'(busy), int'(e.b));
                chk("timeout", int'(timeout), int'(e.t));
            end
        end
    end

    logic [3:0] r_prev_en = 4'b0;
    always @(negedge clk) begin
        chk("onehot0_bus_en", int'($onehot0(bus_en)), 1);
        if (bus_en != 4'b0 && r_prev_en != 4'b0 && bus_en != r_prev_en) begin
            chk("owner_change_gap", int'(bus_en), 0);
        end
        r_prev_en = bus_en;
    end

    initial begin
        reset = 1'b0;
        req   = 4'b0;
        @(negedge clk);
        #1;

        // Reset held with all requests asserted
        req = 4'hF;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_bus_en", int'(bus_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset = 1'b1;
        step(4'hF, 4'b0001, 2'd0, 1'b1, 1'b0);

        // Round robin: each owner holds two cycles then drops for one
        for (int n = 0; n < 4; n++) begin
            step(4'hF, 4'(1 << n), 2'(n), 1'b1, 1'b0);
            step(4'hF & ~4'(1 << n), 4'b0, 2'(n), 1'b1, 1'b0);
            step(4'hF, 4'(1 << ((n + 1) % 4)), 2'((n + 1) % 4), 1'b1, 1'b0);
        end
        step(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, ptr=1
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // No preemption, ptr=3
        step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1000, 4'b0000, 2'd1, 1'b1, 1'b0);
        step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Mid-grant asynchronous reset, ptr=0
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_bus_en", int'(bus_en), 0);
        chk("async_idx", int'(gnt_idx), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        req   = 4'b0;
        @(negedge clk);
        #1;

        // Contended long hold
        step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        repeat (7) step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0011, 4'b0000, 2'd0, 1'b1, 1'b1);
        step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
        repeat (7) step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0011, 4'b0000, 2'd1, 1'b1, 1'b1);
        step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        repeat (16) step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
`endif
        step(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        repeat (2) begin
            @(negedge clk);
            #1;
        end
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_bus_arbiter.md
Name: nibble_bus_arbiter

Overview:
Round-robin arbiter that shares the 4-bit internal data bus between up to NREQ tri-state bus drivers. It turns per-source requests into one-hot drive enables, which connect directly to each bus driver's enable pin. It inserts a mandatory one-cycle turnaround with all enables low between owners, so two drivers are never enabled in the same cycle. It sits in the nibble datapath between the control unit's source requests and the bus driver instances.

Parameters:
NREQ, 4, number of requesters/bus drivers (legal range 2..8)
IDX_W, 2, width of the encoded grant index (must be >= clog2(NREQ))
MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release (used only with ARB_TIMEOUT_EN)
HOLD_W, 4, width of the hold counter (must satisfy MAX_HOLD <= 2^HOLD_W - 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-source bus request, level-sensitive
gnt  output  NREQ  registered one-hot grant
bus_en  output  NREQ  drive enables to the bus drivers; equals gnt
gnt_idx  output  IDX_W  binary index of the current or most recent owner
busy  output  1  high in GRANT and TURNAROUND
timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (reset=0, asynchronous, effective immediately): state=IDLE, gnt=0, bus_en=0, gnt_idx=0, busy=0, timeout=0, priority pointer ptr=0, hold counter=0. Enables must drop without waiting for clk, including in the middle of a grant.
- All outputs are registered. None is combinationally derived from req.
- Arbitration: select the first asserted req[i], searching cyclically from ptr (ptr, ptr+1, ... wrapping modulo NREQ).
- IDLE:
  - No request: stay in IDLE.
  - Any req high at an edge: go to GRANT on that edge. gnt=bus_en=onehot(winner), gnt_idx=winner, busy=1.
  - Latency: 1 edge from request to enable.
- GRANT:
  - Hold the grant while req[owner]=1.
  - Requests from non-owners are ignored; there is no preemption.
  - req[owner]=0 at an edge: go to TURNAROUND. gnt=bus_en=0, ptr=(owner+1) mod NREQ, busy stays 1.
- TURNAROUND:
  - Lasts exactly one cycle with all enables low.
  - Any req high at the next edge: arbitrate with the updated ptr and go directly to GRANT.
  - No request: go to IDLE and set busy=0.
  - The same requester re-requesting also passes through TURNAROUND.
- Invariants:
  - At most one bit of bus_en is high in any cycle.
  - A change of owner always has at least one all-zero bus_en cycle between owners.
  - gnt_idx holds the last owner through TURNAROUND and IDLE.
- Fairness: with all requests held high and each owner releasing after k cycles, grants rotate 0,1,...,NREQ-1,0.
- ptr wraps from NREQ-1 to 0. Invalid parameter combinations trigger a simulation $error.

Optional Feature:
ARB_TIMEOUT_EN
- When defined:
  - The hold counter increments every GRANT cycle and clears on entry to GRANT.
  - When the counter reaches MAX_HOLD and any other req is high, force the transition to TURNAROUND, advance ptr past the owner, and pulse timeout=1 for that cycle.
  - If no other requester is pending, the owner keeps the bus and the counter saturates.
- When undefined: no counter logic, timeout is tied to 0, and an owner holds the bus indefinitely.

Test Plan:
1. Reset: hold reset=0 with req=1111 -> gnt=0000, bus_en=0000, busy=0. Deassert reset -> gnt=0001, gnt_idx=0 after the first edge.
2. Single request: req=0100 from IDLE -> gnt=0100, gnt_idx=2 after 1 edge. Drop req -> bus_en=0000, busy=1 for one cycle, then busy=0 in IDLE.
3. Round robin: req=1111, each owner drops its req for one cycle after 2 grant cycles -> grant sequence 0001,0010,0100,1000,0001, with exactly one all-zero cycle between each.
4. No preemption plus invariants: owner 1 holds while req3 rises -> gnt stays 0010 until req1 drops. TURNAROUND follows, then gnt=1000. A checker asserts $onehot0(bus_en) on every cycle.
5. Mid-grant reset: gnt=0100, then pull reset low between edges -> bus_en=0000 immediately, before the next clk edge. gnt_idx=0.
6. With ARB_TIMEOUT_EN, MAX_HOLD=8, req=0011 held constantly -> gnt=0001 for 8 cycles, a timeout pulse, one zero cycle, then gnt=0010 for 8 cycles. Without the macro, gnt stays 0001 and timeout stays 0.
